// File: rtl/xfer_pkg.sv
// Shared widths, opcode and state encodings for the register-transfer sequencer.
// Also holds the registered control-output bundle and its reset value.
package xfer_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_WRITE = 3'd1,
        OP_LOADA = 3'd2,
        OP_LOADB = 3'd3,
        OP_MOVBA = 3'd4,
        OP_MOVAB = 3'd5,
        OP_ILL6  = 3'd6,
        OP_ILL7  = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXEC    = 3'd1,
        ST_DRIVE   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Every control output lives in this one register so that none of them
    // can see a combinational path from the command inputs.
    typedef struct packed {
        logic              fr_w;
        logic [ADDR_W-1:0] fr_waddr;
        logic [DATA_W-1:0] fr_wdata;
        logic [ADDR_W-1:0] data_a;
        logic [ADDR_W-1:0] data_b;
        logic              sel_a;
        logic              sel_b;
        logic              ld_a;
        logic              ld_b;
        logic              oea;
        logic              oeb;
        logic              done;
        logic              err;
    } ctrl_t;

    localparam ctrl_t CTRL_RESET = '{
        fr_w:     1'b0,
        fr_waddr: '0,
        fr_wdata: '0,
        data_a:   '0,
        data_b:   '0,
        sel_a:    1'b0,
        sel_b:    1'b0,
        ld_a:     1'b0,
        ld_b:     1'b0,
        oea:      1'b1,
        oeb:      1'b1,
        done:     1'b0,
        err:      1'b0
    };

    function automatic logic op_is_move(op_e op);
        return (op == OP_MOVBA) || (op == OP_MOVAB);
    endfunction

    function automatic logic op_is_legal(op_e op);
        return (op != OP_ILL6) && (op != OP_ILL7);
    endfunction

endpackage

// File: rtl/xfer_sequencer.sv
// Command sequencer driving a register file and a shared tristate bus between
// the A and B paths; single-cycle ops go IDLE-EXEC-DONE, moves IDLE-DRIVE-CAPTURE-DONE.
module xfer_sequencer
    import xfer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              FR_W,
    output logic [ADDR_W-1:0] FR_WADDR,
    output logic [DATA_W-1:0] FR_WDATA,
    output logic [ADDR_W-1:0] DataA,
    output logic [ADDR_W-1:0] DataB,
    output logic              SEL_A,
    output logic              SEL_B,
    output logic              LD_A,
    output logic              LD_B,
    output logic              OEA,
    output logic              OEB,
    output logic              done,
    output logic              err
);

    state_e            state_q;
    state_e            state_d;
    op_e               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_d;

    logic              accept;
    op_e               op_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && (state_q == ST_IDLE) && !rst;

    // Outputs are decoded for the state being entered, so on the accept edge
    // the freshly presented command must be used rather than the stale register.
    assign op_n   = accept ? op_e'(cmd_op) : op_q;
    assign addr_n = accept ? cmd_addr      : addr_q;
    assign data_n = accept ? cmd_data      : data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= OP_NOP;
            addr_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            op_q   <= op_e'(cmd_op);
            addr_q <= cmd_addr;
            data_q <= cmd_data;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = op_is_move(op_e'(cmd_op)) ? ST_DRIVE : ST_EXEC;
                end
            end
            ST_EXEC:    state_d = ST_DONE;
            ST_DRIVE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Address/data outputs hold their last value; strobes, selects and bus
    // enables fall back to their idle levels unless the next state asks otherwise.
    always_comb begin
        ctrl_d          = CTRL_RESET;
        ctrl_d.fr_waddr = ctrl_q.fr_waddr;
        ctrl_d.fr_wdata = ctrl_q.fr_wdata;
        ctrl_d.data_a   = ctrl_q.data_a;
        ctrl_d.data_b   = ctrl_q.data_b;
        case (state_d)
            ST_EXEC: begin
                case (op_n)
                    OP_WRITE: begin
                        ctrl_d.fr_w     = 1'b1;
                        ctrl_d.fr_waddr = addr_n;
                        ctrl_d.fr_wdata = data_n;
                    end
                    OP_LOADA: begin
                        ctrl_d.data_a = addr_n;
                        ctrl_d.sel_a  = 1'b1;
                        ctrl_d.ld_a   = 1'b1;
                    end
                    OP_LOADB: begin
                        ctrl_d.data_b = addr_n;
                        ctrl_d.sel_b  = 1'b1;
                        ctrl_d.ld_b   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_DRIVE: begin
                if (op_n == OP_MOVBA) begin
                    ctrl_d.oeb = 1'b0;
                end else begin
                    ctrl_d.oea = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (op_n == OP_MOVBA) begin
                    ctrl_d.oeb  = 1'b0;
                    ctrl_d.ld_a = 1'b1;
                end else begin
                    ctrl_d.oea  = 1'b0;
                    ctrl_d.ld_b = 1'b1;
                end
            end
            ST_DONE: begin
                ctrl_d.done = 1'b1;
                ctrl_d.err  = !op_is_legal(op_n);
            end
            default: ;
        endcase
    end

    // Reset forces the idle levels at the same edge, releasing the bus at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= CTRL_RESET;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign FR_W     = ctrl_q.fr_w;
    assign FR_WADDR = ctrl_q.fr_waddr;
    assign FR_WDATA = ctrl_q.fr_wdata;
    assign DataA    = ctrl_q.data_a;
    assign DataB    = ctrl_q.data_b;
    assign SEL_A    = ctrl_q.sel_a;
    assign SEL_B    = ctrl_q.sel_b;
    assign LD_A     = ctrl_q.ld_a;
    assign LD_B     = ctrl_q.ld_b;
    assign OEA      = ctrl_q.oea;
    assign OEB      = ctrl_q.oeb;
    assign done     = ctrl_q.done;
    assign err      = ctrl_q.err;

endmodule

// File: tb/tb_xfer_sequencer.sv
// Bench for xfer_sequencer: accepted commands go into a scoreboard whose front
// entry predicts every control output cycle by cycle, plus per-scenario checks.
module tb_xfer_sequencer;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_LOADA = 3'd2;
    localparam logic [2:0] OP_LOADB = 3'd3;
    localparam logic [2:0] OP_MOVBA = 3'd4;
    localparam logic [2:0] OP_MOVAB = 3'd5;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [4:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       FR_W;
    logic [4:0] FR_WADDR;
    logic [7:0] FR_WDATA;
    logic [4:0] DataA;
    logic [4:0] DataB;
    logic       SEL_A;
    logic       SEL_B;
    logic       LD_A;
    logic       LD_B;
    logic       OEA;
    logic       OEB;
    logic       done;
    logic       err;

    xfer_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_data  (cmd_data),
        .FR_W      (FR_W),
        .FR_WADDR  (FR_WADDR),
        .FR_WDATA  (FR_WDATA),
        .DataA     (DataA),
        .DataB     (DataB),
        .SEL_A     (SEL_A),
        .SEL_B     (SEL_B),
        .LD_A      (LD_A),
        .LD_B      (LD_B),
        .OEA       (OEA),
        .OEB       (OEB),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [2:0] op;
        logic [4:0] addr;
        logic [7:0] data;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   acc_log[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_count = 0;
    int   last_done = 0;
    bit   mon_en = 0;

    exp_t       m_e;
    int         m_d;
    int         m_dd;
    logic [9:0] m_exp;
    logic [9:0] m_obs;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            sb.delete();
        end else if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            sb.push_back('{op: cmd_op, addr: cmd_addr, data: cmd_data, acc: cyc});
            acc_log.push_back(cyc);
        end
    end

    // Expected vector order: {cmd_ready, FR_W, LD_A, LD_B, SEL_A, SEL_B, OEA, OEB, done, err}
    always @(negedge clk) begin
        if (mon_en) begin
            m_exp = 10'b1000001100;
            m_obs = {cmd_ready, FR_W, LD_A, LD_B, SEL_A, SEL_B, OEA, OEB, done, err};
            if (sb.size() > 0) begin
                m_e  = sb[0];
                m_d  = cyc - m_e.acc;
                m_dd = (m_e.op == OP_MOVBA || m_e.op == OP_MOVAB) ? 3 : 2;
                m_exp[9] = 1'b0;
                m_exp[8] = (m_e.op == OP_WRITE) && (m_d == 1);
                m_exp[7] = ((m_e.op == OP_LOADA) && (m_d == 1)) || ((m_e.op == OP_MOVBA) && (m_d == 2));
                m_exp[6] = ((m_e.op == OP_LOADB) && (m_d == 1)) || ((m_e.op == OP_MOVAB) && (m_d == 2));
                m_exp[5] = (m_e.op == OP_LOADA) && (m_d == 1);
                m_exp[4] = (m_e.op == OP_LOADB) && (m_d == 1);
                m_exp[3] = !((m_e.op == OP_MOVAB) && (m_d == 1 || m_d == 2));
                m_exp[2] = !((m_e.op == OP_MOVBA) && (m_d == 1 || m_d == 2));
                m_exp[1] = (m_d == m_dd);
                m_exp[0] = (m_d == m_dd) && (m_e.op >= 3'd6);
            end
            checks++;
            if (m_obs !== m_exp) begin
                errors++;
                $display("[TB] FAIL cycle_outputs cyc=%0d: got %b expected %b", cyc, m_obs, m_exp);
            end
            if (sb.size() > 0) begin
                if (m_e.op == OP_WRITE && m_d == 1) begin
                    checks++;
                    if ({FR_WADDR, FR_WDATA} !== {m_e.addr, m_e.data}) begin
                        errors++;
                        $display("[TB] FAIL write_addr_data: got %h/%h expected %h/%h", FR_WADDR, FR_WDATA, m_e.addr, m_e.data);
                    end
                end
                if (m_e.op == OP_LOADA && m_d == 1) begin
                    checks++;
                    if (DataA !== m_e.addr) begin
                        errors++;
                        $display("[TB] FAIL loada_addr: got %h expected %h", DataA, m_e.addr);
                    end
                end
                if (m_e.op == OP_LOADB && m_d == 1) begin
                    checks++;
                    if (DataB !== m_e.addr) begin
                        errors++;
                        $display("[TB] FAIL loadb_addr: got %h expected %h", DataB, m_e.addr);
                    end
                end
                if (m_d >= m_dd) void'(sb.pop_front());
            end
            if (done === 1'b1) begin
                done_count++;
                last_done = cyc;
            end
        end
    end

    // Called at a negedge; returns just after the edge that accepted the command.
    task automatic drive_cmd(input logic [2:0] op, input logic [4:0] a, input logic [7:0] dt);
        int n;
        n = 0;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = dt;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: cmd_ready got %b expected 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_addr  = 5'($urandom);
        cmd_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout: cmd_ready got %b expected 1", cmd_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_addr  = 5'd7;
        cmd_data  = 8'hAA;
        repeat (3) @(negedge clk);
        checks++;
        if ({FR_W, FR_WADDR, FR_WDATA, DataA, DataB, SEL_A, SEL_B, LD_A, LD_B, OEA, OEB, done, err} !==
            {1'b0, 5'd0, 8'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got FR_W=%b WADDR=%h WDATA=%h A=%h B=%h OEA=%b OEB=%b done=%b expected 0/0/0/0/0/1/1/0",
                     FR_W, FR_WADDR, FR_WDATA, DataA, DataB, OEA, OEB, done);
        end
        cmd_valid = 1'b0;
        rst       = 1'b0;
        mon_en    = 1'b1;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL ready_after_reset: got ready=%b queued=%0d expected 1/0", cmd_ready, sb.size());
        end
    endtask

    task automatic test_write();
        drive_cmd(OP_WRITE, 5'd0, 8'h06);
        @(negedge clk);
        checks++;
        if ({FR_W, FR_WADDR, FR_WDATA} !== {1'b1, 5'd0, 8'h06}) begin
            errors++;
            $display("[TB] FAIL write_t1: got %b/%h/%h expected 1/00/06", FR_W, FR_WADDR, FR_WDATA);
        end
        @(negedge clk);
        checks++;
        if ({done, FR_W, cmd_ready} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL write_t2: got done/FR_W/ready=%b expected 100", {done, FR_W, cmd_ready});
        end
        @(negedge clk);
        checks++;
        if ({cmd_ready, done} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL write_t3: got ready/done=%b expected 10", {cmd_ready, done});
        end
    endtask

    task automatic test_loada();
        drive_cmd(OP_LOADA, 5'd1, 8'h00);
        @(negedge clk);
        checks++;
        if ({DataA, SEL_A, LD_A, OEA, OEB} !== {5'd1, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("[TB] FAIL loada_t1: got A=%h SEL_A=%b LD_A=%b OEA=%b OEB=%b expected 01/1/1/1/1", DataA, SEL_A, LD_A, OEA, OEB);
        end
        @(negedge clk);
        checks++;
        if ({done, LD_A, SEL_A, DataA} !== {1'b1, 1'b0, 1'b0, 5'd1}) begin
            errors++;
            $display("[TB] FAIL loada_t2: got done=%b LD_A=%b SEL_A=%b A=%h expected 1/0/0/01", done, LD_A, SEL_A, DataA);
        end
        wait_idle();
    endtask

    task automatic test_movba();
        drive_cmd(OP_MOVBA, 5'd3, 8'h00);
        @(negedge clk);
        checks++;
        if ({OEB, OEA, LD_A, SEL_A} !== 4'b0100) begin
            errors++;
            $display("[TB] FAIL movba_drive: got OEB/OEA/LD_A/SEL_A=%b expected 0100", {OEB, OEA, LD_A, SEL_A});
        end
        @(negedge clk);
        checks++;
        if ({OEB, OEA, LD_A, SEL_A, LD_B} !== 5'b01100) begin
            errors++;
            $display("[TB] FAIL movba_capture: got OEB/OEA/LD_A/SEL_A/LD_B=%b expected 01100", {OEB, OEA, LD_A, SEL_A, LD_B});
        end
        @(negedge clk);
        checks++;
        if ({done, OEB, OEA, LD_A, err} !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL movba_done: got done/OEB/OEA/LD_A/err=%b expected 11100", {done, OEB, OEA, LD_A, err});
        end
        wait_idle();
    endtask

    task automatic test_illegal();
        drive_cmd(3'd7, 5'd9, 8'h55);
        @(negedge clk);
        checks++;
        if ({FR_W, LD_A, LD_B, SEL_A, SEL_B, OEA, OEB, done, err} !== 9'b000001100) begin
            errors++;
            $display("[TB] FAIL illegal_t1: got %b expected 000001100", {FR_W, LD_A, LD_B, SEL_A, SEL_B, OEA, OEB, done, err});
        end
        @(negedge clk);
        checks++;
        if ({done, err, FR_W} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL illegal_t2: got done/err/FR_W=%b expected 110", {done, err, FR_W});
        end
        wait_idle();
    endtask

    task automatic test_reset_mid_move();
        int n0;
        drive_cmd(OP_WRITE, 5'd9, 8'h5C);
        wait_idle();
        drive_cmd(OP_LOADB, 5'd4, 8'h00);
        wait_idle();
        drive_cmd(OP_MOVAB, 5'd0, 8'h00);
        n0 = done_count;
        @(negedge clk);
        checks++;
        if ({OEA, OEB} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL movab_drive: got OEA/OEB=%b expected 01", {OEA, OEB});
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({FR_W, FR_WADDR, FR_WDATA, DataA, DataB, SEL_A, SEL_B, LD_A, LD_B, OEA, OEB, done, err} !==
            {1'b0, 5'd0, 8'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL mid_reset_values: got WADDR=%h WDATA=%h B=%h OEA=%b OEB=%b LD_B=%b done=%b expected 00/00/00/1/1/0/0",
                     FR_WADDR, FR_WDATA, DataB, OEA, OEB, LD_B, done);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (done_count != n0) begin
            errors++;
            $display("[TB] FAIL aborted_no_done: got %0d done pulses expected 0", done_count - n0);
        end
        drive_cmd(OP_WRITE, 5'd2, 8'h33);
        @(negedge clk);
        checks++;
        if ({FR_W, FR_WADDR, FR_WDATA} !== {1'b1, 5'd2, 8'h33}) begin
            errors++;
            $display("[TB] FAIL write_after_reset: got %b/%h/%h expected 1/02/33", FR_W, FR_WADDR, FR_WDATA);
        end
        wait_idle();
        checks++;
        if (done_count != n0 + 1) begin
            errors++;
            $display("[TB] FAIL write_after_reset_done: got %0d done pulses expected 1", done_count - n0);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [3];
        logic [4:0] adr [3];
        int         n0;
        int         a0;
        int         n;
        ops = '{OP_WRITE, OP_LOADB, OP_MOVAB};
        adr = '{5'd10, 5'd11, 5'd12};
        n0 = done_count;
        a0 = acc_log.size();
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cmd_op   = ops[i];
            cmd_addr = adr[i];
            cmd_data = 8'h7E;
            n = 0;
            while (cmd_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (n >= 20) begin
                checks++;
                errors++;
                $display("[TB] FAIL b2b_accept_timeout: cmd %0d ready got %b expected 1", i, cmd_ready);
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        wait_idle();
        checks++;
        if (done_count - n0 != 3 || acc_log.size() - a0 != 3) begin
            errors++;
            $display("[TB] FAIL b2b_counts: got done=%0d accepts=%0d expected 3/3", done_count - n0, acc_log.size() - a0);
        end else begin
            checks++;
            if (acc_log[a0+1] - acc_log[a0] != 3 || acc_log[a0+2] - acc_log[a0+1] != 3 || last_done - acc_log[a0] != 9) begin
                errors++;
                $display("[TB] FAIL b2b_spacing: got gaps %0d,%0d last_done=%0d expected 3,3,9",
                         acc_log[a0+1] - acc_log[a0], acc_log[a0+2] - acc_log[a0+1], last_done - acc_log[a0]);
            end
        end
    endtask

    task automatic test_idle_hold();
        cmd_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if ({cmd_ready, FR_WADDR, FR_WDATA, DataA, DataB} !== {1'b1, 5'd10, 8'h7E, 5'd0, 5'd11}) begin
            errors++;
            $display("[TB] FAIL idle_hold: got ready=%b WADDR=%h WDATA=%h A=%h B=%h expected 1/0a/7e/00/0b",
                     cmd_ready, FR_WADDR, FR_WDATA, DataA, DataB);
        end
    endtask

    task automatic test_random();
        int n0;
        n0 = done_count;
        for (int i = 0; i < 10; i++) begin
            drive_cmd(3'($urandom_range(0, 7)), 5'($urandom), 8'($urandom));
            wait_idle();
        end
        checks++;
        if (done_count - n0 != 10) begin
            errors++;
            $display("[TB] FAIL random_done_count: got %0d expected 10", done_count - n0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
        cmd_addr  = '0;
        cmd_data  = '0;
        test_reset();
        test_write();
        test_loada();
        test_movba();
        test_illegal();
        test_reset_mid_move();
        test_back_to_back();
        test_idle_hold();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
